// File: rtl/sdram_sched_pkg.sv
// -----------------------------------------------------------------------------
// sdram_sched_pkg
// Shared types and constants for the SDRAM slot scheduler.
//   state_e          - scheduler FSM states (7)
//   SLOT_CPU/VID/TAPE - slot codes used to select the command field source
//   DEFAULT_CPU_DOUT  - value returned on cpu_dout before the first CPU read
// -----------------------------------------------------------------------------
package sdram_sched_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CPU_CMD,
        CPU_RD,
        VID_CMD,
        VID_RD,
        TAPE_CMD,
        TAPE_RD
    } state_e;

    localparam logic [1:0] SLOT_CPU  = 2'd0;
    localparam logic [1:0] SLOT_VID  = 2'd1;
    localparam logic [1:0] SLOT_TAPE = 2'd2;

    localparam logic [7:0] DEFAULT_CPU_DOUT = 8'hFF;

    // Which requester owns a given state.
    function automatic logic [1:0] slot_of(input state_e s);
        case (s)
            CPU_CMD, CPU_RD: return SLOT_CPU;
            VID_CMD, VID_RD: return SLOT_VID;
            default:         return SLOT_TAPE;
        endcase
    endfunction

    function automatic logic is_cmd_state(input state_e s);
        return (s == CPU_CMD) || (s == VID_CMD) || (s == TAPE_CMD);
    endfunction

endpackage

// File: rtl/sdram_slot_sched.sv
// -----------------------------------------------------------------------------
// sdram_slot_sched
// Shares the single SDRAM command port between the CPU bus, the video fetcher
// and the tape buffer. Every clkref pulse opens a window served in the fixed
// order CPU -> VIDEO -> TAPE; each slot issues at most one command.
//
// Build option: VIDEO_PORT_EN
//   defined   - vid_addr/vid_dout exist, the VIDEO slot reads one word per window
//   undefined - no vid_* ports, the VIDEO slot is skipped (CPU -> TAPE)
//
// Ports
//   clk_sys, reset_n        system clock, synchronous active-low reset
//   clkref                  window-start pulse (1 cycle)
//   cpu_addr/din/oe/we      CPU request, sampled at clkref (we wins over oe)
//   cpu_dout                last CPU read byte, held
//   vid_addr, vid_dout      video word address / last video word (option)
//   tape_addr/din/wr/rd     tape request levels, held until tape_ack toggles
//   tape_dout, tape_ack     last tape read byte / toggles per completed access
//   cmd_valid/ready/we/word/addr/wdata   command handshake to the SDRAM engine
//   rd_valid, rd_data       read return; byte chosen by address bit 0
//   overrun                 sticky: clkref arrived while a window was busy
// -----------------------------------------------------------------------------
module sdram_slot_sched
    import sdram_sched_pkg::*;
#(
    parameter int ADDR_W  = 23,
    parameter int WIN_LEN = 16
) (
    input  logic              clk_sys,
    input  logic              reset_n,
    input  logic              clkref,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [7:0]        cpu_din,
    input  logic              cpu_oe,
    input  logic              cpu_we,
    output logic [7:0]        cpu_dout,
`ifdef VIDEO_PORT_EN
    input  logic [ADDR_W-1:0] vid_addr,
    output logic [15:0]       vid_dout,
`endif
    input  logic [ADDR_W-1:0] tape_addr,
    input  logic [7:0]        tape_din,
    input  logic              tape_wr,
    input  logic              tape_rd,
    output logic [7:0]        tape_dout,
    output logic              tape_ack,
    output logic              cmd_valid,
    input  logic              cmd_ready,
    output logic              cmd_we,
    output logic              cmd_word,
    output logic [ADDR_W-1:0] cmd_addr,
    output logic [7:0]        cmd_wdata,
    input  logic              rd_valid,
    input  logic [15:0]       rd_data,
    output logic              overrun
);

    // A full CPU read + video read + tape read needs a handful of cycles of
    // handshaking; a window shorter than this cannot complete even with an
    // always-ready engine.
    if (WIN_LEN < 8) begin : g_win_len_check
        $error("sdram_slot_sched: WIN_LEN must be at least 8");
    end

    state_e     state;
    state_e     state_d;
    state_e     tape_slot;   // where to go when the tape slot comes up
    state_e     vid_slot;    // where to go when the video slot comes up
    logic       accept;
    logic [7:0] rd_byte;

    // NOTE: every signal assigned in an always_comb gets a default at the top;
    // a path that leaves one unassigned would infer a latch.
    always_comb begin
        accept    = cmd_valid & cmd_ready;
        rd_byte   = cmd_addr[0] ? rd_data[15:8] : rd_data[7:0];
        tape_slot = (tape_wr | tape_rd) ? TAPE_CMD : IDLE;
`ifdef VIDEO_PORT_EN
        vid_slot  = VID_CMD;
`else
        vid_slot  = tape_slot;
`endif
        state_d   = state;

        case (state)
            IDLE:     if (clkref)   state_d = (cpu_we | cpu_oe) ? CPU_CMD : vid_slot;
            // cmd_we still holds the field loaded on entry, so it tells a
            // write (done at accept) from a read (wait for data).
            CPU_CMD:  if (accept)   state_d = cmd_we ? vid_slot : CPU_RD;
            CPU_RD:   if (rd_valid) state_d = vid_slot;
            VID_CMD:  if (accept)   state_d = VID_RD;
            VID_RD:   if (rd_valid) state_d = tape_slot;
            TAPE_CMD: if (accept)   state_d = cmd_we ? IDLE : TAPE_RD;
            TAPE_RD:  if (rd_valid) state_d = IDLE;
            default:                state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge value of every other register.
    always_ff @(posedge clk_sys) begin
        // NOTE: reset is synchronous and covers every flop here, including the
        // held output data; an abandoned command simply disappears.
        if (!reset_n) begin
            state     <= IDLE;
            cmd_valid <= 1'b0;
            cmd_we    <= 1'b0;
            cmd_word  <= 1'b0;
            cmd_addr  <= '0;
            cmd_wdata <= '0;
            cpu_dout  <= DEFAULT_CPU_DOUT;
`ifdef VIDEO_PORT_EN
            vid_dout  <= '0;
`endif
            tape_dout <= '0;
            tape_ack  <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            state <= state_d;

            // Valid drops in the cycle after an accept even when the next slot
            // starts right away, which guarantees a one-cycle gap between
            // commands.
            cmd_valid <= is_cmd_state(state_d) && !accept;

            if (clkref && (state != IDLE)) begin
                overrun <= 1'b1;
            end

            // Command fields are captured once on slot entry and held until
            // the handshake, independent of later requester activity.
            if ((state_d != state) && is_cmd_state(state_d)) begin
                case (slot_of(state_d))
                    SLOT_CPU: begin
                        cmd_we    <= cpu_we;
                        cmd_word  <= 1'b0;
                        cmd_addr  <= cpu_addr;
                        cmd_wdata <= cpu_din;
                    end
`ifdef VIDEO_PORT_EN
                    SLOT_VID: begin
                        cmd_we    <= 1'b0;
                        cmd_word  <= 1'b1;
                        cmd_addr  <= vid_addr;
                        cmd_wdata <= '0;
                    end
`endif
                    default: begin
                        // tape_wr has priority when both levels are held
                        cmd_we    <= tape_wr;
                        cmd_word  <= 1'b0;
                        cmd_addr  <= tape_addr;
                        cmd_wdata <= tape_din;
                    end
                endcase
            end

            // Read data is only taken in a read-wait state; strays are dropped.
            if (rd_valid) begin
                case (state)
                    CPU_RD:  cpu_dout  <= rd_byte;
`ifdef VIDEO_PORT_EN
                    VID_RD:  vid_dout  <= rd_data;
`endif
                    TAPE_RD: tape_dout <= rd_byte;
                    default: ;
                endcase
            end

            if (((state == TAPE_CMD) && accept && cmd_we) ||
                ((state == TAPE_RD) && rd_valid)) begin
                tape_ack <= ~tape_ack;
            end
        end
    end

endmodule
